// File: rtl/bili_arty_top.sv
// Arty-100T board top: UART-framed two-lane fp32 sign-manipulation ALU (ReLU / negate / abs)
// with completion status published on the io_ja header.
module bili_arty_top #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       io_CLK100MHZ,
  input  logic       io_ck_rst,
  input  logic       io_uart_txd_in,
  output logic       io_uart_rxd_out,
  output logic [7:0] io_ja,
  output logic       io_led,
  output logic       io_jd_0,
  output logic       io_jd_3,
  input  logic [3:0] io_sw,
  input  logic [3:0] io_btn,
  input  logic [7:0] io_jb,
  input  logic [7:0] io_jc,
  input  logic       io_jd_1,
  input  logic       io_jd_2,
  input  logic       io_jd_4,
  input  logic       io_jd_5,
  input  logic       io_jd_6,
  input  logic       io_jd_7,
  input  logic       io_ck_ioa,
  input  logic       io_eth_col,
  input  logic       io_eth_crs,
  input  logic       io_eth_rx_clk,
  input  logic       io_eth_rx_dv,
  input  logic [3:0] io_eth_rxd,
  input  logic       io_eth_rxerr,
  input  logic       io_eth_tx_clk
);
  localparam int DATA_W = 32;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] SYNC = 8'hCA;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_FUNC, S_DATA, S_EXEC, S_TX, S_DONE} state_t;

  logic clk, rst;
  assign clk = io_CLK100MHZ;
  assign rst = io_ck_rst;

  logic unused_ins;
  assign unused_ins = ^{io_sw, io_btn, io_jb, io_jc, io_jd_1, io_jd_2, io_jd_4, io_jd_5,
                        io_jd_6, io_jd_7, io_ck_ioa, io_eth_col, io_eth_crs, io_eth_rx_clk,
                        io_eth_rx_dv, io_eth_rxd, io_eth_rxerr, io_eth_tx_clk};

  function automatic logic [DATA_W-1:0] lane_op(input logic [7:0] f, input logic [DATA_W-1:0] x);
    case (f)
      8'h01:   lane_op = x[DATA_W-1] ? '0 : x;
      8'h02:   lane_op = {~x[DATA_W-1], x[DATA_W-2:0]};
      8'h03:   lane_op = {1'b0, x[DATA_W-2:0]};
      default: lane_op = x;
    endcase
  endfunction

  rx_state_t       rx_st;
  logic            rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            rx_valid;

  // RX: synchronise, find falling edge, confirm start at mid-bit, then sample every bit period
  always_ff @(posedge clk) begin
    rx_valid <= 1'b0;
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      rx_st   <= R_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      io_jd_0 <= 1'b0;
    end else begin
      rx_s1 <= io_uart_txd_in;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_st)
        R_IDLE: if (rx_s3 && !rx_s2) begin
          rx_st   <= R_START;
          rx_cnt  <= '0;
          io_jd_0 <= 1'b1;
        end
        R_START: if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (rx_s2) begin
            rx_st   <= R_IDLE;
            io_jd_0 <= 1'b0;
          end else begin
            rx_st <= R_DATA;
          end
        end else rx_cnt <= rx_cnt + 1'b1;
        R_DATA: if (rx_cnt == FULL) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= R_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        R_STOP: if (rx_cnt == FULL) begin
          rx_cnt   <= '0;
          rx_st    <= R_IDLE;
          io_jd_0  <= 1'b0;
          rx_valid <= rx_s2;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  state_t          st;
  logic [7:0]      func_r;
  logic [63:0]     op_p0;
  logic [63:0]     tx_data_p1;
  logic [2:0]      byte_cnt;
  logic [CW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= S_IDLE;
      io_ja           <= 8'h00;
      io_led          <= 1'b0;
      io_uart_rxd_out <= 1'b1;
      io_jd_3         <= 1'b0;
      byte_cnt        <= '0;
      tx_cnt          <= '0;
      tx_bit          <= '0;
    end else begin
      case (st)
        S_IDLE, S_DONE: if (rx_valid && rx_sh == SYNC) begin
          st     <= S_HDR1;
          io_ja  <= 8'h00;
          io_led <= 1'b1;
        end
        S_HDR1: if (rx_valid) begin
          if (rx_sh == SYNC) begin
            st    <= S_FUNC;
            io_ja <= 8'h02;
          end else begin
            st     <= S_IDLE;
            io_led <= 1'b0;
          end
        end
        S_FUNC: if (rx_valid) begin
          func_r   <= rx_sh;
          byte_cnt <= '0;
          st       <= S_DATA;
        end
        S_DATA: if (rx_valid) begin
          op_p0    <= {rx_sh, op_p0[63:8]};
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt == 3'd7) st <= S_EXEC;
        end
        // EXEC -> TX boundary: results registered, start bit of byte 0 driven the next cycle
        S_EXEC: begin
          tx_data_p1      <= {lane_op(func_r, op_p0[63:32]), lane_op(func_r, op_p0[31:0])};
          io_uart_rxd_out <= 1'b0;
          io_jd_3         <= 1'b1;
          tx_cnt          <= '0;
          tx_bit          <= '0;
          byte_cnt        <= '0;
          st              <= S_TX;
        end
        S_TX: if (tx_cnt == FULL) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            if (byte_cnt == 3'd7) begin
              st      <= S_DONE;
              io_ja   <= 8'h01;
              io_led  <= 1'b0;
              io_jd_3 <= 1'b0;
            end else begin
              byte_cnt        <= byte_cnt + 3'd1;
              tx_bit          <= '0;
              io_uart_rxd_out <= 1'b0;
              tx_data_p1      <= {8'h00, tx_data_p1[63:8]};
            end
          end else begin
            tx_bit          <= tx_bit + 4'd1;
            io_uart_rxd_out <= (tx_bit == 4'd8) ? 1'b1 : tx_data_p1[tx_bit[2:0]];
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bili_arty_top.sv
// Bench for bili_arty_top: table vectors, hand-written corner sequences and random frames
// checked against a lane-level behavioural model, with a shortened bit period.
module tb_bili_arty_top;
  localparam int CPB = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_in = 1'b1;
  logic       rxd_out;
  logic [7:0] ja;
  logic       led, jd0, jd3;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mon_q[$];
  time        start_t[$];

  always #5 clk = ~clk;

  bili_arty_top #(.CLKS_PER_BIT(CPB)) dut (
    .io_CLK100MHZ(clk), .io_ck_rst(rst), .io_uart_txd_in(uart_in), .io_uart_rxd_out(rxd_out),
    .io_ja(ja), .io_led(led), .io_jd_0(jd0), .io_jd_3(jd3),
    .io_sw(4'h0), .io_btn(4'h0), .io_jb(8'h00), .io_jc(8'h00),
    .io_jd_1(1'b0), .io_jd_2(1'b0), .io_jd_4(1'b0), .io_jd_5(1'b0), .io_jd_6(1'b0), .io_jd_7(1'b0),
    .io_ck_ioa(1'b0), .io_eth_col(1'b0), .io_eth_crs(1'b0), .io_eth_rx_clk(1'b0),
    .io_eth_rx_dv(1'b0), .io_eth_rxd(4'h0), .io_eth_rxerr(1'b0), .io_eth_tx_clk(1'b0)
  );

  typedef struct {
    logic [7:0]  f;
    logic [31:0] a, b, ea, eb;
  } vec_t;

  function automatic logic [31:0] model(input logic [7:0] f, input logic [31:0] x);
    case (f)
      8'h01:   return ($signed(x) < 0) ? 32'h0 : x;
      8'h02:   return x ^ 32'h8000_0000;
      8'h03:   return x & 32'h7fff_ffff;
      default: return x;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_in = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      wait_cyc(CPB);
    end
    uart_in = stop;
    wait_cyc(CPB);
    uart_in = 1'b1;
  endtask

  // Host-side UART receiver on the DUT transmit line
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge rxd_out);
      start_t.push_back($time);
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (rxd_out == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          #1;
          b[i] = rxd_out;
        end
        repeat (CPB) @(posedge clk);
        #1;
        if (rxd_out) mon_q.push_back(b);
      end
    end
  end

  task automatic send_frame(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic chk_hdr);
    send_byte(8'hCA, 1'b1);
    send_byte(8'hCA, 1'b1);
    if (chk_hdr) begin
      check("ja_busy_after_hdr", {56'd0, ja}, 64'h02);
      check("led_after_hdr", {63'd0, led}, 64'h1);
    end
    send_byte(f, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], 1'b1);
  endtask

  task automatic run_frame(input string name, input logic [7:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ea, input logic [31:0] eb);
    logic [31:0] ra, rb;
    int  n;
    time t1;
    mon_q.delete();
    start_t.delete();
    send_frame(f, a, b, 1'b1);
    check({name, "_tx_busy"}, {56'd0, ja, jd3, led}, {54'd0, 8'h02, 1'b1, 1'b1});
    n = 0;
    while (ja !== 8'h01 && n < 100 * CPB) begin
      wait_cyc(1);
      n++;
    end
    t1 = $time;
    check({name, "_done"}, {56'd0, ja}, 64'h01);
    check({name, "_idle_after"}, {61'd0, led, jd3, rxd_out}, 64'h1);
    check({name, "_nbytes"}, 64'(mon_q.size()), 64'd8);
    if (start_t.size() > 0)
      check({name, "_done_latency"}, 64'((t1 - start_t[0] - 1) / 10), 64'(80 * CPB));
    else
      check({name, "_done_latency"}, 64'hFFFF, 64'(80 * CPB));
    ra = 'x;
    rb = 'x;
    if (mon_q.size() >= 8) begin
      ra = {mon_q[3], mon_q[2], mon_q[1], mon_q[0]};
      rb = {mon_q[7], mon_q[6], mon_q[5], mon_q[4]};
    end
    check({name, "_lane0"}, {32'd0, ra}, {32'd0, ea});
    check({name, "_lane1"}, {32'd0, rb}, {32'd0, eb});
  endtask

  initial begin
    vec_t tbl[6];
    int   lows, n;
    tbl[0] = '{8'h01, 32'hBF80_0000, 32'h4000_0000, 32'h0000_0000, 32'h4000_0000};
    tbl[1] = '{8'h02, 32'h3F80_0000, 32'hC120_0000, 32'hBF80_0000, 32'h4120_0000};
    tbl[2] = '{8'h03, 32'hC049_0FDB, 32'h8000_0000, 32'h4049_0FDB, 32'h0000_0000};
    tbl[3] = '{8'h00, 32'hDEAD_BEEF, 32'h8000_0001, 32'hDEAD_BEEF, 32'h8000_0001};
    tbl[4] = '{8'h01, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
    tbl[5] = '{8'h5A, 32'h1234_5678, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321};

    // Reset state and a quiet transmit line afterwards
    rst = 1'b1;
    wait_cyc(10);
    check("reset_outputs", {52'd0, rxd_out, ja, led, jd0, jd3}, {52'd0, 1'b1, 8'h00, 3'b000});
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 2000; i++) begin
      wait_cyc(1);
      if (rxd_out !== 1'b1) lows++;
    end
    check("quiet_tx_after_reset", 64'(lows), 64'd0);
    check("ja_idle_after_reset", {56'd0, ja}, 64'h00);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].ea, tbl[i].eb);

    // Bad header: no reply, status cleared by the accepted first sync byte
    mon_q.delete();
    send_byte(8'hCA, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_cyc(20 * CPB);
    check("badhdr_no_reply", 64'(mon_q.size()), 64'd0);
    check("badhdr_ja_led", {55'd0, ja, led}, {55'd0, 8'h00, 1'b0});
    run_frame("after_badhdr", tbl[1].f, tbl[1].a, tbl[1].b, tbl[1].ea, tbl[1].eb);

    // Short low glitch on the receive line must not start a byte
    uart_in = 1'b0;
    wait_cyc(2);
    uart_in = 1'b1;
    wait_cyc(2);
    check("glitch_rx_busy", {63'd0, jd0}, 64'h1);
    wait_cyc(CPB);
    check("glitch_rx_drop", {62'd0, jd0, led}, 64'h0);

    // Framing error: a sync byte with a low stop bit is discarded
    send_byte(8'hCA, 1'b0);
    wait_cyc(2 * CPB);
    check("framing_discard", {55'd0, ja, led}, {55'd0, 8'h01, 1'b0});
    run_frame("after_framing", 8'h00, 32'hA5A5_0F0F, 32'hFFFF_FFFF, 32'hA5A5_0F0F, 32'hFFFF_FFFF);

    // Reset during the start bit of the third transmitted byte
    mon_q.delete();
    send_frame(8'h02, 32'h1111_1111, 32'h2222_2222, 1'b0);
    n = 0;
    while (mon_q.size() < 2 && n < 40 * CPB) begin
      wait_cyc(1);
      n++;
    end
    while (rxd_out !== 1'b0 && n < 40 * CPB) begin
      wait_cyc(1);
      n++;
    end
    check("midtx_reached_byte3", {63'd0, rxd_out}, 64'h0);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    check("midtx_reset_outputs", {52'd0, rxd_out, ja, led, jd0, jd3}, {52'd0, 1'b1, 8'h00, 3'b000});
    rst = 1'b0;
    wait_cyc(15 * CPB);
    run_frame("after_midtx", 8'h03, 32'hC000_0001, 32'h8000_0000, 32'h4000_0001, 32'h0000_0000);

    // Random frames against the lane model
    for (int i = 0; i < 5; i++) begin
      logic [7:0]  f;
      logic [31:0] a, b;
      n = int'($urandom_range(0, 4));
      f = (n == 4) ? 8'($urandom) : 8'(n);
      a = $urandom;
      b = $urandom;
      run_frame($sformatf("rnd%0d_f%02h", i, f), f, a, b, model(f, a), model(f, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
